avalon_sample_master: RTL and testbench

AVALON_SAMPLE_MASTER -- requirements
Module: avalon_sample_master

---
 rtl/avalon_sample_master_pkg.sv | 23 ++
 rtl/avalon_sample_master_fifo.sv | 51 +++++
 rtl/avalon_sample_master.sv | 144 ++++++++++++++
 tb/tb_avalon_sample_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_sample_master_pkg.sv
// Shared types and constants for the Avalon sample master: FSM encoding,
// bus widths, default frame/FIFO sizes and the frame-length clamp.
package avalon_sample_master_pkg;

  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 16;
  localparam int LEN_W          = 9;
  localparam int FRAME_MAX_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned max_len);
    return (32'(len) > max_len) ? LEN_W'(max_len) : len;
  endfunction

endpackage

// File: rtl/avalon_sample_master_fifo.sv
// Synchronous readback skid FIFO with occupancy count; a pop on an empty FIFO
// is ignored and a push on a full FIFO is accepted only alongside a pop.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avalon_sample_master.sv
// Streams a frame of samples to Avalon-MM memory, then reads it back through
// a credit-limited skid FIFO onto the output stream.
// Streams use valid/ready: a transfer happens on a rising edge where both are high.
module avalon_sample_master
  import avalon_sample_master_pkg::*;
#(
  parameter int FRAME_MAX  = FRAME_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [LEN_W-1:0]         frame_len,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        ddr_addr,
  output logic                     ddr_read,
  output logic                     ddr_write,
  output logic signed [DATA_W-1:0] ddr_writedata,
  input  logic signed [DATA_W-1:0] ddr_readdata,
  input  logic                     ddr_readdatavalid,
  input  logic                     ddr_waitrequest,
  output state_t                   state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len, wcnt, rcnt, pcnt, start_len;
  logic [CW-1:0]     outstanding, fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty, credit_ok;
  logic              wr_done, rd_acc, push, pop;

  assign start_len = clamp_len(frame_len, FRAME_MAX);
  assign wr_done   = ddr_write && !ddr_waitrequest;
  assign rd_acc    = ddr_read && !ddr_waitrequest;
  assign push      = ddr_readdatavalid && (state == ST_READ);
  assign pop       = out_valid && out_ready;
  // Reads in flight plus buffered words never exceed the FIFO depth.
  assign credit_ok = ((CW+1)'(outstanding) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);
  assign state_dbg = state;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (ddr_readdata),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = (start_len == '0) ? ST_DONE : ST_WRITE;
      ST_WRITE: if (wr_done && (wcnt == len - LEN_W'(1))) state_nx = ST_READ;
      ST_READ:  if (pop && (pcnt == len - LEN_W'(1))) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, before the state register clears.
  always_comb begin
    ddr_addr      = '0;
    ddr_read      = 1'b0;
    ddr_write     = 1'b0;
    ddr_writedata = '0;
    in_ready      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    if (reset_n) begin
      unique case (state)
        ST_WRITE: begin
          busy          = 1'b1;
          ddr_write     = in_valid;
          ddr_writedata = in_data;
          ddr_addr      = base + ADDR_W'(wcnt);
          in_ready      = !ddr_waitrequest;
        end
        ST_READ: begin
          busy     = 1'b1;
          ddr_read = (rcnt < len) && credit_ok;
          ddr_addr = base + ADDR_W'(rcnt);
        end
        ST_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

  assign out_valid = reset_n && !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base        <= '0;
      len         <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      pcnt        <= '0;
      outstanding <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          base        <= base_addr;
          len         <= start_len;
          wcnt        <= '0;
          rcnt        <= '0;
          pcnt        <= '0;
          outstanding <= '0;
        end
        ST_WRITE: if (wr_done) wcnt <= wcnt + LEN_W'(1);
        ST_READ: begin
          if (rd_acc) rcnt <= rcnt + LEN_W'(1);
          if (pop)    pcnt <= pcnt + LEN_W'(1);
          unique case ({rd_acc, push})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_sample_master.sv
// Directed bench for avalon_sample_master: table of frames plus a mid-read
// reset sequence, against a behavioural Avalon memory slave.
module tb_avalon_sample_master;
  import avalon_sample_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, start, in_valid, in_ready, out_valid, out_ready;
  logic               busy, done, ddr_read, ddr_write, ddr_readdatavalid, ddr_waitrequest;
  logic [15:0]        base_addr, ddr_addr;
  logic [8:0]         frame_len;
  logic signed [15:0] in_data, out_data, ddr_writedata, ddr_readdata;
  state_t             state_dbg;

  avalon_sample_master #(.FRAME_MAX(256), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .frame_len         (frame_len),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .done              (done),
    .ddr_addr          (ddr_addr),
    .ddr_read          (ddr_read),
    .ddr_write         (ddr_write),
    .ddr_writedata     (ddr_writedata),
    .ddr_readdata      (ddr_readdata),
    .ddr_readdatavalid (ddr_readdatavalid),
    .ddr_waitrequest   (ddr_waitrequest),
    .state_dbg         (state_dbg)
  );

  // ---------------- memory slave with selectable read latency ----------------
  logic [15:0] mem [0:65535];
  logic [3:0]  rv_sh = 4'b0;
  logic [15:0] rd_sh [4];
  int          rd_lat = 1;
  int          both_cnt = 0;
  logic [15:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

  assign ddr_readdatavalid = rv_sh[0];
  assign ddr_readdata      = rd_sh[0];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rd_sh[i] <= rd_sh[i+1];
    rv_sh <= {1'b0, rv_sh[3:1]} | ((ddr_read && !ddr_waitrequest) ? (4'b1 << (rd_lat - 1)) : 4'b0);
    if (ddr_write && !ddr_waitrequest) begin
      mem[ddr_addr] <= ddr_writedata;
      wr_addr_q.push_back(ddr_addr);
      wr_data_q.push_back(ddr_writedata);
    end
    if (ddr_read && !ddr_waitrequest) begin
      rd_sh[rd_lat-1] <= mem[ddr_addr];
      rd_addr_q.push_back(ddr_addr);
    end
    if (ddr_read && ddr_write) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]        base;
    logic [8:0]         frame_len;
    int                 exp_len;
    logic signed [15:0] s0, s1, s2, s3;
    int                 wr_stall_at;
    int                 rd_hold;
    int                 restart_at;
    logic [15:0]        exp_last_addr;
    int                 exp_done_cyc;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [15:0] sample_of(input vec_t v, input int i);
    case (i)
      0:       return v.s0;
      1:       return v.s1;
      2:       return v.s2;
      3:       return v.s3;
      default: return 16'(i * 37 - 300);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_frame(input vec_t v, input int idx);
    logic [15:0] smp [256];
    logic [15:0] st_addr, st_data, exp_a;
    int L, cyc, src, pops, rd_start, first_out, done_cyc, done_cnt, wr0, rd0, stall_k;
    string tag;
    L = v.exp_len;
    tag = $sformatf("v%0d", idx);
    for (int i = 0; i < L; i++) smp[i] = sample_of(v, i);
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(smp[i]);
    wr0 = wr_addr_q.size();
    rd0 = rd_addr_q.size();
    st_addr = '0; st_data = '0;
    start = 1'b1; base_addr = v.base; frame_len = v.frame_len;
    @(posedge clk); @(negedge clk);
    start = 1'b0; base_addr = '0; frame_len = '0;
    cyc = 0; src = 0; pops = 0; rd_start = -1; first_out = -1;
    done_cyc = -1; done_cnt = 0; stall_k = 0;
    while (cyc < 2000 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
      start           = (cyc == v.restart_at);
      base_addr       = start ? 16'hAAAA : 16'h0000;
      frame_len       = start ? 9'd3 : 9'd0;
      ddr_waitrequest = (v.wr_stall_at >= 0 && cyc >= v.wr_stall_at && cyc < v.wr_stall_at + 3);
      in_valid        = (src < L);
      in_data         = (src < L) ? smp[src] : 16'h0000;
      #1;
      if (ddr_read && rd_start < 0) rd_start = cyc;
      out_ready = !(v.rd_hold > 0 && rd_start >= 0 && cyc - rd_start < v.rd_hold);
      #1;
      if (ddr_waitrequest) begin
        check($sformatf("%s_stall%0d_in_ready", tag, stall_k), in_ready, 0);
        if (stall_k == 0) begin
          exp_a = v.base + 16'(v.wr_stall_at);
          check($sformatf("%s_stall_addr", tag), ddr_addr, exp_a);
          check($sformatf("%s_stall_wdata", tag), {16'h0, ddr_writedata}, smp[src]);
          check($sformatf("%s_stall_write", tag), ddr_write, 1);
          st_addr = ddr_addr;
          st_data = ddr_writedata;
        end else begin
          check($sformatf("%s_stall%0d_addr_hold", tag, stall_k), ddr_addr, st_addr);
          check($sformatf("%s_stall%0d_wdata_hold", tag, stall_k), {16'h0, ddr_writedata}, st_data);
        end
        stall_k++;
      end
      if (v.rd_hold > 0 && rd_start >= 0 && cyc == rd_start + v.rd_hold - 1) begin
        check($sformatf("%s_hold_reads", tag), rd_addr_q.size() - rd0, 4);
        check($sformatf("%s_hold_read_low", tag), ddr_read, 0);
        check($sformatf("%s_hold_out_valid", tag), out_valid, 1);
      end
      if (in_valid && in_ready) src++;
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) check($sformatf("%s_extra_pop", tag), 1, 0);
        else check($sformatf("%s_out%0d", tag, pops - 1), {16'h0, out_data}, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check($sformatf("%s_busy_in_done", tag), busy, 0);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1)
        check($sformatf("%s_after_done", tag), {busy, done}, 2'b00);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    start = 1'b0; ddr_waitrequest = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check($sformatf("%s_done_seen", tag), done_cyc >= 0, 1);
    check($sformatf("%s_done_count", tag), done_cnt, 1);
    if (v.exp_done_cyc >= 0) check($sformatf("%s_done_cycle", tag), done_cyc, v.exp_done_cyc);
    check($sformatf("%s_pops", tag), pops, L);
    check($sformatf("%s_wr_count", tag), wr_addr_q.size() - wr0, L);
    check($sformatf("%s_rd_count", tag), rd_addr_q.size() - rd0, L);
    for (int i = 0; i < L && wr0 + i < wr_addr_q.size(); i++) begin
      exp_a = v.base + 16'(i);
      check($sformatf("%s_wr_addr%0d", tag, i), wr_addr_q[wr0 + i], exp_a);
      check($sformatf("%s_wr_data%0d", tag, i), wr_data_q[wr0 + i], smp[i]);
    end
    for (int i = 0; i < L && rd0 + i < rd_addr_q.size(); i++) begin
      exp_a = v.base + 16'(i);
      check($sformatf("%s_rd_addr%0d", tag, i), rd_addr_q[rd0 + i], exp_a);
    end
    if (L > 0 && wr_addr_q.size() >= wr0 + L) begin
      check($sformatf("%s_last_wr_addr", tag), wr_addr_q[wr0 + L - 1], v.exp_last_addr);
      check($sformatf("%s_last_rd_addr", tag), rd_addr_q[rd0 + L - 1], v.exp_last_addr);
    end
    if (L > 0 && v.rd_hold == 0) check($sformatf("%s_latency", tag), first_out - rd_start, 2);
  endtask

  task automatic reset_midread();
    int src, cyc, bad, rd0;
    rd_lat = 3;
    rd0 = rd_addr_q.size();
    start = 1'b1; base_addr = 16'h0500; frame_len = 9'd8;
    @(posedge clk); @(negedge clk);
    start = 1'b0; base_addr = '0; frame_len = '0;
    src = 0; cyc = 0;
    while (cyc < 200 && rd_addr_q.size() - rd0 < 2) begin
      in_valid = (src < 8);
      in_data  = 16'(src + 1);
      #1;
      if (in_valid && in_ready) src++;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check("rst_two_reads_issued", rd_addr_q.size() - rd0, 2);
    check("rst_state_before", state_dbg, ST_READ);
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    check("rst_during_ctrl", {ddr_read, ddr_write, in_ready, out_valid, busy, done}, 6'b0);
    @(posedge clk); @(negedge clk);
    check("rst_after_state", state_dbg, ST_IDLE);
    check("rst_after_ctrl", {ddr_read, ddr_write, in_ready, out_valid, busy, done}, 6'b0);
    check("rst_after_addr", ddr_addr, 16'h0);
    check("rst_after_wdata", {16'h0, ddr_writedata}, 32'h0);
    check("rst_after_out_data", {16'h0, out_data}, 32'h0);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      #1;
      if (out_valid || busy || ddr_read || ddr_write) bad++;
      @(posedge clk); @(negedge clk);
    end
    check("rst_late_return_ignored", bad, 0);
    rd_lat = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; frame_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1; ddr_waitrequest = 1'b0;
    #1;
    check("reset_first_cycle_ctrl", {ddr_read, ddr_write, in_ready, out_valid, busy, done}, 6'b0);
    repeat (3) @(negedge clk);
    check("reset_state", state_dbg, ST_IDLE);
    check("reset_ctrl", {ddr_read, ddr_write, in_ready, out_valid, busy, done}, 6'b0);
    check("reset_addr", ddr_addr, 16'h0);
    check("reset_wdata", {16'h0, ddr_writedata}, 32'h0);
    check("reset_out_data", {16'h0, out_data}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ctrl", {ddr_read, ddr_write, in_ready, out_valid, busy, done}, 6'b0);

    vecs[0] = '{16'h0010, 9'd4,   4,   16'sd1,   -16'sd2,   16'sd3,   -16'sd4,  -1, 0,  -1, 16'h0013, 10};
    vecs[1] = '{16'hFFFE, 9'd4,   4,   16'sd100, -16'sd100, 16'sd7,   -16'sd7,  -1, 0,  -1, 16'h0001, 10};
    vecs[2] = '{16'h0200, 9'd8,   8,   16'sd11,  16'sd22,   -16'sd33, 16'sd44,  -1, 20, -1, 16'h0207, -1};
    vecs[3] = '{16'h1234, 9'd4,   4,   16'sd5,   16'sd6,    16'sd7,   16'sd8,   2,  0,  -1, 16'h1237, 13};
    vecs[4] = '{16'h0300, 9'd0,   0,   16'sd0,   16'sd0,    16'sd0,   16'sd0,   -1, 0,  -1, 16'h0000, 0};
    vecs[5] = '{16'h0400, 9'd6,   6,   -16'sd1,  16'sd32767, 16'h8000, 16'sd0,  -1, 0,  2,  16'h0405, 14};
    vecs[6] = '{16'h8000, 9'd300, 256, 16'sd9,   -16'sd9,   16'sd90,  -16'sd90, -1, 0,  -1, 16'h80FF, 514};

    for (int v = 0; v < 7; v++) run_frame(vecs[v], v);

    reset_midread();
    run_frame(vecs[0], 7);

    check("never_read_and_write", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
